// File: rtl/serdes_word_aligner_if.sv
// AXI-Stream style word bus driven by the serdes word aligner.
// Carries one DATA_WIDTH word per handshake plus an end-of-frame marker.
interface serdes_word_aligner_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/serdes_word_aligner.sv
// Hunts for a sync word in the recovered bit stream, locks word alignment and streams
// frame words out through a 2-entry buffer. Define SERDES_ALIGNER_STATS_EN for sync_err_cnt_o.
module serdes_word_aligner #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = DATA_WIDTH'(8'hA5),
    parameter int                    FRAME_WORDS = 4,
    parameter int                    MAX_MISS    = 2
) (
    input  logic                   clk_phase,
    input  logic                   rst_n,
    input  logic                   bit_in_i,
    input  logic                   bit_in_valid_i,
    serdes_word_aligner_if.master  m_axis,
    output logic                   locked_o,
`ifdef SERDES_ALIGNER_STATS_EN
    output logic [15:0]            sync_err_cnt_o,
`endif
    output logic                   overflow_o
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int WW = $clog2(FRAME_WORDS + 1);
    localparam int MW = $clog2(MAX_MISS + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] WORD_SYNC = WW'(FRAME_WORDS);
    localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISS - 1);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-2:0] sr_q, sr_d;
    logic [BW-1:0]         bitCnt_q, bitCnt_d;
    logic [WW-1:0]         wordCnt_q, wordCnt_d;
    logic [MW-1:0]         missCnt_q, missCnt_d;
    logic [DATA_WIDTH-1:0] window;
    logic                  pushReq;
    logic                  pushLast;

    logic [DATA_WIDTH-1:0] memData_q [0:1];
    logic                  memLast_q [0:1];
    logic                  rdPtr_q, wrPtr_q;
    logic [1:0]            count_q, count_d;
    logic                  overflow_q;
    logic                  bufEmpty, bufFull, pop, pushOk;

    // The top bit of the shift register would be shifted out by the window, so it is never stored.
    assign window = {sr_q, bit_in_i};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bitCnt_d  = bitCnt_q;
        wordCnt_d = wordCnt_q;
        missCnt_d = missCnt_q;
        pushReq   = 1'b0;
        pushLast  = 1'b0;
        if (bit_in_valid_i) begin
            sr_d = window[DATA_WIDTH-2:0];
            if (state_q == HUNT) begin
                if (window == SYNC_WORD) begin
                    state_d   = LOCKED;
                    bitCnt_d  = '0;
                    wordCnt_d = '0;
                    missCnt_d = '0;
                end
            end else if (bitCnt_q == BIT_LAST) begin
                bitCnt_d = '0;
                if (wordCnt_q == WORD_SYNC) begin
                    wordCnt_d = '0;
                    if (window == SYNC_WORD) begin
                        missCnt_d = '0;
                    end else if (missCnt_q == MISS_LAST) begin
                        state_d   = HUNT;
                        missCnt_d = '0;
                    end else begin
                        missCnt_d = missCnt_q + 1'b1;
                    end
                end else begin
                    pushReq   = 1'b1;
                    pushLast  = (wordCnt_q == WORD_LAST);
                    wordCnt_d = wordCnt_q + 1'b1;
                end
            end else begin
                bitCnt_d = bitCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_phase) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            bitCnt_q  <= '0;
            wordCnt_q <= '0;
            missCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bitCnt_q  <= bitCnt_d;
            wordCnt_q <= wordCnt_d;
            missCnt_q <= missCnt_d;
        end
    end

    assign bufEmpty = (count_q == 2'd0);
    assign bufFull  = (count_q == 2'd2);
    assign pop      = !bufEmpty && m_axis.tready;
    // A full buffer still takes a word when its head leaves in the same cycle.
    assign pushOk   = pushReq && (!bufFull || pop);

    always_comb begin
        count_d = count_q;
        case ({pushOk, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_phase) begin
        if (!rst_n) begin
            memData_q[0] <= '0;
            memData_q[1] <= '0;
            memLast_q[0] <= 1'b0;
            memLast_q[1] <= 1'b0;
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
            count_q      <= 2'd0;
            overflow_q   <= 1'b0;
        end else begin
            if (pushOk) begin
                memData_q[wrPtr_q] <= window;
                memLast_q[wrPtr_q] <= pushLast;
                wrPtr_q            <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_d;
            if (pushReq && bufFull && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef SERDES_ALIGNER_STATS_EN
    logic [15:0] syncErr_q;
    logic        syncMiss;

    assign syncMiss = bit_in_valid_i && (state_q == LOCKED) && (bitCnt_q == BIT_LAST)
                      && (wordCnt_q == WORD_SYNC) && (window != SYNC_WORD);

    always_ff @(posedge clk_phase) begin
        if (!rst_n) begin
            syncErr_q <= 16'd0;
        end else if (syncMiss && (syncErr_q != 16'hFFFF)) begin
            syncErr_q <= syncErr_q + 16'd1;
        end
    end

    assign sync_err_cnt_o = syncErr_q;
`endif

    assign m_axis.tdata  = memData_q[rdPtr_q];
    assign m_axis.tlast  = memLast_q[rdPtr_q];
    assign m_axis.tvalid = !bufEmpty;
    assign locked_o      = (state_q == LOCKED);
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Directed self-checking bench for serdes_word_aligner with default parameters.
// Exercises sync_err_cnt_o as well when SERDES_ALIGNER_STATS_EN is defined.
module tb_serdes_word_aligner;

    logic clk_phase;
    logic rst_n;
    logic bit_in;
    logic bit_in_valid;
    logic locked;
    logic overflow;
`ifdef SERDES_ALIGNER_STATS_EN
    logic [15:0] syncErrCnt;
`endif

    serdes_word_aligner_if #(.DATA_WIDTH(8)) axis ();

    serdes_word_aligner dut (
        .clk_phase      (clk_phase),
        .rst_n          (rst_n),
        .bit_in_i       (bit_in),
        .bit_in_valid_i (bit_in_valid),
        .m_axis         (axis.master),
        .locked_o       (locked),
`ifdef SERDES_ALIGNER_STATS_EN
        .sync_err_cnt_o (syncErrCnt),
`endif
        .overflow_o     (overflow)
    );

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0] capData[$];
    logic       capLast[$];
    logic [7:0] expData[$];
    logic       expLast[$];

    initial clk_phase = 1'b0;
    always #5 clk_phase = ~clk_phase;

    // Words are recorded on the falling edge, when the handshake about to complete is stable.
    always @(negedge clk_phase) begin
        if (rst_n && axis.tvalid && axis.tready) begin
            capData.push_back(axis.tdata);
            capLast.push_back(axis.tlast);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic v);
        bit_in       = b;
        bit_in_valid = v;
        @(posedge clk_phase);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) applyStimulus(v[i], 1'b1);
    endtask

    // Sends a data word with ready high and checks m_tvalid rises exactly one cycle after its last bit.
    task automatic sendWordChk(input string tag, input logic [7:0] v, input logic last);
        for (int i = 7; i >= 1; i--) applyStimulus(v[i], 1'b1);
        checkOutput({tag, "_pre_valid"}, axis.tvalid, 1'b0);
        applyStimulus(v[0], 1'b1);
        checkOutput({tag, "_valid"}, axis.tvalid, 1'b1);
        checkOutput({tag, "_data"}, axis.tdata, v);
        checkOutput({tag, "_last"}, axis.tlast, last);
    endtask

    task automatic sendSyncChk(input string tag, input logic lockedAfter);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 1; i--) applyStimulus(s[i], 1'b1);
        applyStimulus(s[0], 1'b1);
        checkOutput({tag, "_locked"}, locked, lockedAfter);
    endtask

    task automatic sendPrefix();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
    endtask

    task automatic doReset();
        rst_n        = 1'b0;
        bit_in       = 1'b0;
        bit_in_valid = 1'b0;
        axis.tready  = 1'b1;
        repeat (2) @(posedge clk_phase);
        #1;
        rst_n = 1'b1;
        capData.delete();
        capLast.delete();
        expData.delete();
        expLast.delete();
    endtask

    task automatic expectWord(input logic [7:0] d, input logic l);
        expData.push_back(d);
        expLast.push_back(l);
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "_count"}, capData.size(), expData.size());
        for (int i = 0; i < expData.size(); i++) begin
            if (i < capData.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, i), capData[i], expData[i]);
                checkOutput($sformatf("%s_last%0d", tag, i), capLast[i], expLast[i]);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bit_in       = 1'b0;
        bit_in_valid = 1'b0;
        axis.tready  = 1'b1;

        // Reset values, then a long run of zeros never locks.
        doReset();
        checkOutput("rst_tvalid", axis.tvalid, 1'b0);
        checkOutput("rst_tdata", axis.tdata, 8'h00);
        checkOutput("rst_tlast", axis.tlast, 1'b0);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
`ifdef SERDES_ALIGNER_STATS_EN
        checkOutput("rst_syncerr", syncErrCnt, 16'd0);
`endif
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("zeros_locked%0d", i), locked, 1'b0);
            checkOutput($sformatf("zeros_tvalid%0d", i), axis.tvalid, 1'b0);
            checkOutput($sformatf("zeros_ovf%0d", i), overflow, 1'b0);
        end

        // Lock and stream one frame with per-word latency checks.
        doReset();
        sendPrefix();
        for (int i = 7; i >= 1; i--) applyStimulus(((8'hA5 >> i) & 8'h01) != 0, 1'b1);
        checkOutput("t2_locked_pre", locked, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t2_locked", locked, 1'b1);
        sendWordChk("t2_w11", 8'h11, 1'b0);
        sendWordChk("t2_w22", 8'h22, 1'b0);
        sendWordChk("t2_w33", 8'h33, 1'b0);
        sendWordChk("t2_w44", 8'h44, 1'b1);
        sendSyncChk("t2_sync", 1'b1);
        sendWordChk("t2_w55", 8'h55, 1'b0);
        idleCycles(3);
        expectWord(8'h11, 1'b0); expectWord(8'h22, 1'b0); expectWord(8'h33, 1'b0);
        expectWord(8'h44, 1'b1); expectWord(8'h55, 1'b0);
        checkStream("t2");
        checkOutput("t2_overflow", overflow, 1'b0);

        // Back-pressure: buffer fills with 11/22, 33 and 44 are dropped.
        doReset();
        axis.tready = 1'b0;
        sendPrefix();
        sendByte(8'hA5);
        sendByte(8'h11);
        sendByte(8'h22);
        checkOutput("t3_hold_data", axis.tdata, 8'h11);
        checkOutput("t3_hold_ovf", overflow, 1'b0);
        sendByte(8'h33);
        checkOutput("t3_ovf", overflow, 1'b1);
        checkOutput("t3_hold_data2", axis.tdata, 8'h11);
        sendByte(8'h44);
        checkOutput("t3_hold_data3", axis.tdata, 8'h11);
        checkOutput("t3_hold_last", axis.tlast, 1'b0);
        checkOutput("t3_hold_valid", axis.tvalid, 1'b1);
        axis.tready = 1'b1;
        idleCycles(5);
        expectWord(8'h11, 1'b0); expectWord(8'h22, 1'b0);
        checkStream("t3");
        checkOutput("t3_drained", axis.tvalid, 1'b0);
        checkOutput("t3_ovf_sticky", overflow, 1'b1);

        // Sync misses: one isolated miss keeps lock, two consecutive drop it.
        doReset();
        sendPrefix();
        sendSyncChk("t4_lock", 1'b1);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
        sendSyncChk("t4_s1", 1'b1);
        sendByte(8'h55); sendByte(8'h66); sendByte(8'h77); sendByte(8'h88);
        sendByte(8'hA4);
        checkOutput("t4_miss1_locked", locked, 1'b1);
`ifdef SERDES_ALIGNER_STATS_EN
        checkOutput("t4_syncerr1", syncErrCnt, 16'd1);
`endif
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
        sendSyncChk("t4_s3", 1'b1);
`ifdef SERDES_ALIGNER_STATS_EN
        checkOutput("t4_syncerr_hold", syncErrCnt, 16'd1);
`endif
        sendByte(8'h05); sendByte(8'h06); sendByte(8'h07); sendByte(8'h08);
        sendByte(8'hA4);
        checkOutput("t4_miss2_locked", locked, 1'b1);
        sendByte(8'h09); sendByte(8'h0A); sendByte(8'h0B); sendByte(8'h0C);
        for (int i = 7; i >= 1; i--) applyStimulus(((8'hA4 >> i) & 8'h01) != 0, 1'b1);
        checkOutput("t4_miss3_pre", locked, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4_lost", locked, 1'b0);
`ifdef SERDES_ALIGNER_STATS_EN
        checkOutput("t4_syncerr3", syncErrCnt, 16'd3);
`endif
        sendSyncChk("t4_relock", 1'b1);
        sendByte(8'h0D);
        idleCycles(3);
        expectWord(8'h11, 1'b0); expectWord(8'h22, 1'b0); expectWord(8'h33, 1'b0); expectWord(8'h44, 1'b1);
        expectWord(8'h55, 1'b0); expectWord(8'h66, 1'b0); expectWord(8'h77, 1'b0); expectWord(8'h88, 1'b1);
        expectWord(8'h01, 1'b0); expectWord(8'h02, 1'b0); expectWord(8'h03, 1'b0); expectWord(8'h04, 1'b1);
        expectWord(8'h05, 1'b0); expectWord(8'h06, 1'b0); expectWord(8'h07, 1'b0); expectWord(8'h08, 1'b1);
        expectWord(8'h09, 1'b0); expectWord(8'h0A, 1'b0); expectWord(8'h0B, 1'b0); expectWord(8'h0C, 1'b1);
        expectWord(8'h0D, 1'b0);
        checkStream("t4");

        // Reset mid-frame flushes a buffered word and restarts the hunt.
        doReset();
        sendPrefix();
        sendByte(8'hA5);
        sendWordChk("t5_w11", 8'h11, 1'b0);
        idleCycles(1);
        axis.tready = 1'b0;
        sendByte(8'h22);
        checkOutput("t5_buffered", axis.tvalid, 1'b1);
        sendByte(8'h33);
        rst_n        = 1'b0;
        bit_in_valid = 1'b0;
        @(posedge clk_phase);
        #1;
        checkOutput("t5_rst_tvalid", axis.tvalid, 1'b0);
        checkOutput("t5_rst_locked", locked, 1'b0);
        checkOutput("t5_rst_ovf", overflow, 1'b0);
        rst_n       = 1'b1;
        axis.tready = 1'b1;
        capData.delete();
        capLast.delete();
        sendSyncChk("t5_relock", 1'b1);
        sendByte(8'h66); sendByte(8'h77); sendByte(8'h88); sendByte(8'h99);
        idleCycles(3);
        expectWord(8'h66, 1'b0); expectWord(8'h77, 1'b0); expectWord(8'h88, 1'b0); expectWord(8'h99, 1'b1);
        checkStream("t5");

        // Idle cycles with garbage on bit_in must not disturb alignment.
        doReset();
        begin
            logic [7:0] stream [9];
            stream = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h55, 8'h00, 8'h00};
            applyStimulus(1'b1, 1'b1); applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b1); applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b1); applyStimulus(1'b0, 1'b0);
            for (int w = 0; w < 7; w++) begin
                for (int i = 7; i >= 0; i--) begin
                    applyStimulus(stream[w][i], 1'b1);
                    applyStimulus(~stream[w][i], 1'b0);
                end
            end
        end
        idleCycles(3);
        checkOutput("t6_locked", locked, 1'b1);
        expectWord(8'h11, 1'b0); expectWord(8'h22, 1'b0); expectWord(8'h33, 1'b0);
        expectWord(8'h44, 1'b1); expectWord(8'h55, 1'b0);
        checkStream("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
